divider_core: RTL and testbench

//  Iterative restoring unsigned divider datapath and control; sits directly downstream of the start/run

---
 rtl/divider_pkg.sv | 14 +
 rtl/divider_core_if.sv | 33 +++
 rtl/divider_core_div_step.sv | 29 ++
 rtl/divider_core.sv | 118 +++++++++++
 tb/tb_divider_core.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider.
//   state_t   : control states of divider_core (IDLE, ITER, DONE)
//   WIDTH_DEF : default operand/result width
package divider_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_core_if.sv
// Operand/result bundle between the start/run controller (master) and
// divider_core (slave).
//   run                  : start request level from the controller
//   dividend, divisor    : operands, captured by the divider on accept
//   quotient, remainder  : results, valid from check until the next accept
//   check                : one-cycle completion pulse
//   busy                 : divider is in ITER or DONE
//   div_zero             : present only when DIVIDER_DIV0_FAST_EN is defined
interface divider_core_if #(parameter int WIDTH = divider_pkg::WIDTH_DEF);

  logic             run;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             check;
  logic             busy;

`ifdef DIVIDER_DIV0_FAST_EN
  logic             div_zero;

  modport master (output run, dividend, divisor,
                  input  quotient, remainder, check, busy, div_zero);
  modport slave  (input  run, dividend, divisor,
                  output quotient, remainder, check, busy, div_zero);
`else
  modport master (output run, dividend, divisor,
                  input  quotient, remainder, check, busy);
  modport slave  (input  run, dividend, divisor,
                  output quotient, remainder, check, busy);
`endif

endinterface

// File: rtl/divider_core_div_step.sv
// One combinational restoring-division iteration.
//   rem_in  : partial remainder before this step (always < divisor)
//   q_msb   : next dividend bit shifted in (MSB of the quotient shift register)
//   divisor : denominator
//   rem_out : partial remainder after this step
//   qbit    : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  // The trial value keeps the full partial remainder plus one extra bit, so a
  // divisor with its MSB set cannot overflow the compare.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  assign trial = {rem_in, q_msb};
  assign qbit  = (trial >= {1'b0, divisor});
  // When qbit is set the true difference is below divisor, so the low WIDTH
  // bits of the modular subtraction are exact.
  assign diff    = trial[WIDTH-1:0] - divisor;
  assign rem_out = qbit ? diff : trial[WIDTH-1:0];

endmodule

// File: rtl/divider_core.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
//   Clk, Reset : clock (posedge) and asynchronous active-high reset
//   bus        : divider_core_if.slave (run/operands in, results/check/busy out)
// Optional macro DIVIDER_DIV0_FAST_EN: a zero divisor skips the iterations,
// finishes in DONE right after accept and raises div_zero with the results.
//
// state | meaning
// IDLE  | waiting for run; results hold the previous operation
// ITER  | one restoring step per clock, MSB first, WIDTH steps
// DONE  | check pulse for one cycle, then back to IDLE
module divider_core
  import divider_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic Clk,
  input  logic Reset,
  divider_core_if.slave bus
);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_sh, d_reg, r_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             check_reg, busy_reg;
  logic [WIDTH-1:0] r_next;
  logic             qbit;
  logic             last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_reg),
    .q_msb   (q_sh[WIDTH-1]),
    .divisor (d_reg),
    .rem_out (r_next),
    .qbit    (qbit)
  );

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.run) begin
          next_state = ITER;
`ifdef DIVIDER_DIV0_FAST_EN
          if (bus.divisor == '0) next_state = DONE;
`endif
        end
      end
      ITER:    if (last_step) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef DIVIDER_DIV0_FAST_EN
  logic div_zero_reg;
  assign bus.div_zero = div_zero_reg;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      q_sh          <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      check_reg     <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef DIVIDER_DIV0_FAST_EN
      div_zero_reg  <= 1'b0;
`endif
    end else begin
      state     <= next_state;
      // Registered from next_state so check/busy come straight off flops.
      check_reg <= (next_state == DONE);
      busy_reg  <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (bus.run) begin
            q_sh  <= bus.dividend;
            d_reg <= bus.divisor;
            r_reg <= '0;
            cnt   <= '0;
`ifdef DIVIDER_DIV0_FAST_EN
            div_zero_reg <= 1'b0;
            if (bus.divisor == '0) begin
              quotient_reg  <= '1;
              remainder_reg <= bus.dividend;
              div_zero_reg  <= 1'b1;
            end
`endif
          end
        end
        ITER: begin
          q_sh  <= {q_sh[WIDTH-2:0], qbit};
          r_reg <= r_next;
          cnt   <= cnt + CNT_W'(1);
          if (last_step) begin
            quotient_reg  <= {q_sh[WIDTH-2:0], qbit};
            remainder_reg <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.check     = check_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_divider_core.sv
// Scoreboard bench for divider_core (WIDTH=8): directed cases, reset mid-run,
// back-to-back held run, operand/run toggling during ITER, random operands.
module tb_divider_core;
  import divider_pkg::*;

  localparam int W = 8;
`ifdef DIVIDER_DIV0_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  divider_core_if #(.WIDTH(W)) bus ();

  divider_core #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   last_lat = 0;
  bit   prev_hold = 1'b0;
  logic prev_check = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [W-1:0] d);
    return (FAST && d == '0) ? 0 : W;
  endfunction

  // Called at a negedge; waits for IDLE, drives one operation, returns at the
  // negedge right after the accepting edge.
  task automatic drive_op(input logic [W-1:0] n, input logic [W-1:0] d,
                          input bit hold, input bit toggle, input bit track);
    exp_t e;
    int   waited = 0;
    while (bus.busy !== 1'b0 && waited < 64) begin
      @(negedge Clk);
      waited++;
    end
    if (waited >= 64) check_eq("idle_timeout", bus.busy, 0);
    bus.dividend = n;
    bus.divisor  = d;
    bus.run      = 1'b1;
    if (track) begin
      e.q   = (d == '0) ? {W{1'b1}} : n / d;
      e.r   = (d == '0) ? n : n % d;
      e.dz  = FAST && (d == '0);
      e.cyc = cyc + 1 + lat_of(d);
      sb.push_back(e);
    end
    if (hold && prev_hold) check_eq("spacing", cyc + 1 - last_acc, last_lat + 2);
    prev_hold = hold;
    last_acc  = cyc + 1;
    last_lat  = lat_of(d);
    @(negedge Clk);
    if (!hold) bus.run = 1'b0;
    if (toggle) begin
      repeat (3) begin
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
        bus.run      = 1'($urandom_range(0, 1));
        @(negedge Clk);
      end
      bus.run = 1'b0;
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset && bus.check === 1'b1) begin
      check_eq("pulse_width", prev_check, 0);
      if (sb.size() == 0) begin
        check_eq("spurious_check", bus.check, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("quotient", bus.quotient, mon_e.q);
        check_eq("remainder", bus.remainder, mon_e.r);
        check_eq("latency", cyc, mon_e.cyc);
        check_eq("busy_in_done", bus.busy, 1);
`ifdef DIVIDER_DIV0_FAST_EN
        check_eq("div_zero", bus.div_zero, mon_e.dz);
`endif
      end
    end
    prev_check = bus.check;
  end

  logic [W-1:0] dir_n [6] = '{8'd100, 8'd255, 8'd5, 8'd200, 8'd255, 8'd77};
  logic [W-1:0] dir_d [6] = '{8'd7,   8'd1,   8'd9, 8'd200, 8'd128, 8'd0};

  initial begin
    int waited;
    bus.run      = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    Reset        = 1'b1;
    repeat (3) @(negedge Clk);
    check_eq("rst_quotient", bus.quotient, 0);
    check_eq("rst_remainder", bus.remainder, 0);
    check_eq("rst_check", bus.check, 0);
    check_eq("rst_busy", bus.busy, 0);
`ifdef DIVIDER_DIV0_FAST_EN
    check_eq("rst_div_zero", bus.div_zero, 0);
`endif
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 6; i++) drive_op(dir_n[i], dir_d[i], 1'b0, 1'b0, 1'b1);

    // Reset in the middle of an operation: no check pulse may follow.
    drive_op(8'd100, 8'd7, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    check_eq("midrst_quotient", bus.quotient, 0);
    check_eq("midrst_remainder", bus.remainder, 0);
    check_eq("midrst_check", bus.check, 0);
    check_eq("midrst_busy", bus.busy, 0);
    @(negedge Clk);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (W + 4) @(negedge Clk);
    drive_op(8'd200, 8'd13, 1'b0, 1'b0, 1'b1);

    // run held high: back-to-back operations.
    for (int i = 0; i < 6; i++) drive_op(W'(37 * i + 50), W'(i + 3), 1'b1, 1'b0, 1'b1);
    bus.run = 1'b0;

    // run/operands wiggled during ITER.
    drive_op(8'd100, 8'd7, 1'b0, 1'b1, 1'b1);
    drive_op(8'd255, 8'd200, 1'b0, 1'b1, 1'b1);
    drive_op(8'd9, 8'd3, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 3000; i++) drive_op(W'($urandom), W'($urandom), 1'b1, 1'b0, 1'b1);
    bus.run = 1'b0;

    waited = 0;
    while (sb.size() != 0 && waited < 64) begin
      @(negedge Clk);
      waited++;
    end
    check_eq("sb_drain", sb.size(), 0);
    repeat (3) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
